// File: rtl/dut_port_arbiter.sv
// rtl/dut_port_arbiter.sv - round-robin arbiter sharing the dut write/read methods among NREQ requesters
module dut_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [3*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output logic              resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [2:0]        write_address,
    output logic              write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [2:0]        read_address,
    output logic              read_en,
    input  logic              read_data,
    input  logic              read_rdy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] cand;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic          cmd_write;
    logic [7:0]    to_cnt;
    logic          rdy;
    logic          timed_out;
    logic          fire;
    logic [2:0]    addr_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[3*i +: 3];
        end
    end

    // Search upward from the slot after the last-served requester, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign rdy       = cmd_write ? write_rdy : read_rdy;
    assign timed_out = (to_cnt == 8'(TIMEOUT));
    // Abort wins over a late rdy so no enable is issued on the abort cycle.
    assign fire      = (state == ISSUE) && rdy && !timed_out;
    assign write_en  = fire && cmd_write;
    assign read_en   = fire && !cmd_write;
    assign busy      = (state != IDLE);
    assign req_ready = ((state == IDLE) && grant_found && RST_N) ? (NREQ'(1) << grant_idx) : '0;
    assign resp_valid = (state == DONE) ? (NREQ'(1) << owner) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = ISSUE;
            ISSUE:   if (fire || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            rr_ptr        <= PW'(NREQ - 1);
            owner         <= '0;
            cmd_write     <= 1'b0;
            to_cnt        <= '0;
            write_address <= '0;
            write_data    <= 1'b0;
            read_address  <= '0;
            resp_rdata    <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner     <= grant_idx;
                        cmd_write <= req_write[grant_idx];
                        to_cnt    <= '0;
                        if (req_write[grant_idx]) begin
                            write_address <= addr_arr[grant_idx];
                            write_data    <= req_wdata[grant_idx];
                        end else begin
                            read_address  <= addr_arr[grant_idx];
                        end
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= cmd_write ? 1'b0 : read_data;
                    end else if (timed_out) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                DONE: rr_ptr <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_port_arbiter.sv
// tb/tb_dut_port_arbiter.sv - scoreboard bench for dut_port_arbiter
module tb_dut_port_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [3*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic              resp_rdata;
    logic              resp_err;
    logic              busy;
    logic [2:0]        write_address;
    logic              write_data;
    logic              write_en;
    logic              write_rdy;
    logic [2:0]        read_address;
    logic              read_en;
    logic              read_data;
    logic              read_rdy;
    logic [7:0]        mem;

    typedef struct { int id; int gap; } grant_t;
    typedef struct { bit wr; int addr; int data; int delay; } en_t;
    typedef struct { int id; int err; int rdata; int delay; } resp_t;

    grant_t exp_grant [$];
    en_t    exp_en [$];
    resp_t  exp_resp [$];

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int g_cyc = 0;

    dut_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign read_data = mem[read_address];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        grant_t g;
        en_t    e;
        resp_t  r;
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                if (|req_ready) begin
                    check("grant_expected", int'(exp_grant.size() > 0), 1);
                    if (exp_grant.size() > 0) begin
                        g = exp_grant.pop_front();
                        check("grant_id", int'(req_ready), 1 << g.id);
                        if (g.gap > 0) check("grant_gap", cyc - g_cyc, g.gap);
                    end
                    g_cyc = cyc;
                end
                if (write_en || read_en) begin
                    check("en_exclusive", int'(write_en & read_en), 0);
                    check("en_expected", int'(exp_en.size() > 0), 1);
                    if (exp_en.size() > 0) begin
                        e = exp_en.pop_front();
                        check("en_kind", int'(write_en), int'(e.wr));
                        if (e.wr) begin
                            check("write_address", int'(write_address), e.addr);
                            check("write_data", int'(write_data), e.data);
                        end else begin
                            check("read_address", int'(read_address), e.addr);
                        end
                        check("en_delay", cyc - g_cyc, e.delay);
                    end
                end
                if (|resp_valid) begin
                    check("resp_expected", int'(exp_resp.size() > 0), 1);
                    if (exp_resp.size() > 0) begin
                        r = exp_resp.pop_front();
                        check("resp_id", int'(resp_valid), 1 << r.id);
                        check("resp_err", int'(resp_err), r.err);
                        check("resp_rdata", int'(resp_rdata), r.rdata);
                        check("resp_delay", cyc - g_cyc, r.delay);
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] gs;
        @(negedge CLK);
        gs = req_ready;
        @(posedge CLK);
        #1;
        req_valid = req_valid & ~gs;
    endtask

    task automatic set_req(input int i, input bit wr, input int addr, input bit wd);
        req_valid[i]         = 1'b1;
        req_write[i]         = wr;
        req_addr[3*i +: 3]   = addr[2:0];
        req_wdata[i]         = wd;
    endtask

    task automatic exp_txn(input int id, input bit wr, input int addr, input int data,
                           input int en_d, input int resp_d, input int err, input int gap);
        int rd;
        rd = (!wr && err == 0) ? int'(mem[addr[2:0]]) : 0;
        exp_grant.push_back('{id, gap});
        if (en_d > 0) exp_en.push_back('{wr, addr, data, en_d});
        exp_resp.push_back('{id, err, rd, resp_d});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_grant.size() + exp_en.size() + exp_resp.size() != 0 || busy || req_valid != '0)
               && n < 200) begin
            step();
            n++;
        end
        check("drain_left", exp_grant.size() + exp_en.size() + exp_resp.size(), 0);
        check("drain_idle", int'(busy), 0);
    endtask

    initial begin
        mem       = 8'b0110_1010;
        RST_N     = 1'b0;
        req_valid = '1;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        fork
            monitor();
        join_none

        // Reset state, with every requester asserting.
        repeat (2) @(negedge CLK);
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_en", int'({write_en, read_en}), 0);
        check("rst_addr", int'({write_address, read_address}), 0);
        check("rst_data", int'({write_data, resp_err, resp_rdata}), 0);
        req_valid = '0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Single write, minimum latency.
        set_req(0, 1'b1, 3, 1'b1);
        exp_txn(0, 1'b1, 3, 1, 1, 2, 0, 0);
        drain();

        // Write timeout with write_rdy stuck low.
        write_rdy = 1'b0;
        set_req(3, 1'b1, 6, 1'b1);
        exp_txn(3, 1'b1, 6, 1, 0, TIMEOUT + 2, 1, 0);
        drain();
        write_rdy = 1'b1;

        // Round robin over four reads, requester 0 re-requesting in its response cycle.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, 1'b0);
        exp_txn(0, 1'b0, 0, 0, 1, 2, 0, 0);
        for (int i = 1; i < NREQ; i++) exp_txn(i, 1'b0, i, 0, 1, 2, 0, 3);
        exp_txn(0, 1'b0, 0, 0, 1, 2, 0, 3);
        step();
        step();
        set_req(0, 1'b0, 0, 1'b0);
        drain();

        // Read with read_rdy low for four ISSUE cycles.
        read_rdy = 1'b0;
        set_req(2, 1'b0, 5, 1'b0);
        exp_txn(2, 1'b0, 5, 0, 5, 6, 0, 0);
        step();
        repeat (4) step();
        read_rdy = 1'b1;
        drain();

        // Requester 1 withdraws before grant; requester 3 is served.
        set_req(0, 1'b0, 1, 1'b0);
        exp_txn(0, 1'b0, 1, 0, 1, 2, 0, 0);
        exp_txn(3, 1'b0, 6, 0, 1, 2, 0, 3);
        step();
        set_req(1, 1'b1, 2, 1'b1);
        set_req(3, 1'b0, 6, 1'b0);
        step();
        req_valid[1] = 1'b0;
        drain();

        // Leave the round-robin pointer at requester 0.
        set_req(0, 1'b1, 2, 1'b1);
        exp_txn(0, 1'b1, 2, 1, 1, 2, 0, 0);
        drain();

        // Asynchronous reset in the middle of an ISSUE cycle.
        set_req(1, 1'b1, 4, 1'b0);
        exp_grant.push_back('{1, 0});
        step();
        check("pre_reset_en", int'(write_en), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_en", int'({write_en, read_en}), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_resp", int'({resp_valid, resp_err, resp_rdata}), 0);
        check("mid_rst_addr", int'({write_address, write_data, read_address}), 0);
        set_req(0, 1'b1, 5, 1'b1);
        set_req(1, 1'b1, 4, 1'b0);
        set_req(2, 1'b0, 3, 1'b0);
        check("mid_rst_ready", int'(req_ready), 0);
        exp_txn(0, 1'b1, 5, 1, 1, 2, 0, 0);
        exp_txn(1, 1'b1, 4, 0, 1, 2, 0, 3);
        exp_txn(2, 1'b0, 3, 0, 1, 2, 0, 3);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dut_port_arbiter.md
# dut_port_arbiter

Round-robin arbiter that shares the single write port and single read port of the `dut` register block among `NREQ` requesters. Each requester issues one write or read transaction at a time. The arbiter sequences each transaction onto the dut's Bluespec-style enable/ready methods and returns read data or a timeout error to the requester that issued it. It sits between the test/initiator agents and `dut`, and owns all of the `dut`'s method enables.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 15: consecutive not-ready cycles before a transaction aborts, range 1..255.

Ports:
- `CLK`, input, 1: single clock; all state changes on its rising edge.
- `RST_N`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, NREQ: per-requester request pending.
- `req_write`, input, NREQ: 1 = write, 0 = read.
- `req_addr`, input, 3*NREQ: packed addresses; requester i uses bits [3i+2:3i].
- `req_wdata`, input, NREQ: write data bit per requester.
- `req_ready`, output, NREQ: one-hot, one-cycle accept pulse.
- `resp_valid`, output, NREQ: one-hot, one-cycle completion pulse to the originating requester.
- `resp_rdata`, output, 1: read data; valid with `resp_valid`.
- `resp_err`, output, 1: timeout abort flag; valid with `resp_valid`.
- `busy`, output, 1: high in ISSUE and DONE.
- `write_address`, output, 3: address driven to the dut write method.
- `write_data`, output, 1: data driven to the dut write method.
- `write_en`, output, 1: dut write method enable.
- `write_rdy`, input, 1: dut write method ready.
- `read_address`, output, 3: address driven to the dut read method.
- `read_en`, output, 1: dut read method enable.
- `read_data`, input, 1: dut read method return value.
- `read_rdy`, input, 1: dut read method ready.

## Operation
- FSM states: IDLE, ISSUE, DONE. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, select the winner `w`: the first set bit searching upward from `rr_ptr+1`, wrapping modulo NREQ.
  - Pulse `req_ready[w]`.
  - Latch op, address and wdata into the command register, and latch `w` as the owner.
  - Go to ISSUE.
  - If no `req_valid` is high, stay in IDLE.
- ISSUE, write command:
  - `write_address` and `write_data` are driven from the command register throughout ISSUE.
  - `write_en = write_rdy`; this is a combinational AND with the state, so `en` is never high while `rdy` is low.
  - On the cycle `en` is high, go to DONE with err=0.
- ISSUE, read command:
  - `read_address` is driven from the command register.
  - `read_en = read_rdy`.
  - On the cycle `en` is high, register `read_data` into `resp_rdata` and go to DONE.
- Timeout counter:
  - Clears on entry to ISSUE.
  - Increments each ISSUE cycle while the relevant `rdy` is low.
  - On reaching TIMEOUT, go to DONE with err=1. No `en` pulse is issued, and `resp_rdata` is 0.
- DONE:
  - Pulse `resp_valid[owner]`, with `resp_err` and `resp_rdata` valid.
  - Set `rr_ptr = owner`.
  - Go to IDLE.
- Requester rules:
  - Request fields must stay stable from `req_valid` rising until `req_ready`.
  - Dropping `req_valid` before grant withdraws the request with no side effect.
  - Fields are sampled only in the grant cycle.
- Only one transaction is ever outstanding. Write and read enables are never high in the same cycle.
- Outside ISSUE:
  - `write_en` and `read_en` are 0.
  - Addresses and data hold their last command values.
- Counter width is 8 bits. With TIMEOUT=255 the counter never wraps, because an abort fires first.

## Timing
- Reset values: every output is 0, including `req_ready`, `resp_valid`, `resp_rdata`, `resp_err`, `busy`, both addresses, `write_data`, `write_en` and `read_en`. `rr_ptr` resets to NREQ-1, so requester 0 has first priority.
- Reset asserted mid-transaction: `en` drops immediately (asynchronous), no response is issued, and the owner must re-request.
- Latency:
  - Grant cycle T.
  - Earliest `en` at T+1 (if `rdy` is high).
  - `resp_valid` at T+2.
  - Next grant at T+3.
  - Peak throughput is one transaction per 3 cycles.
- `rdy` low for k cycles, with k < TIMEOUT, adds k cycles.
- Abort: `resp_valid` arrives TIMEOUT+1 cycles after entering ISSUE.
- Simultaneous requests resolve round-robin. A requester that has just been served has lowest priority in the next IDLE.
- A requester may re-assert `req_valid` in the same cycle as its `resp_valid`. It is considered in the following IDLE cycle.

## Test plan
- Reset, then only requester 0 writes addr 3, data 1, with `write_rdy`=1:
  - `req_ready[0]` pulses at T.
  - `write_en`=1 with addr 3, data 1 at T+1.
  - `resp_valid[0]` with err=0 at T+2.
- All 4 requesters hold reads of addr 0..3:
  - Grants occur in order 0,1,2,3,0.
  - Grants are spaced 3 cycles apart.
  - `read_en` is never high together with `write_en`.
- Requester 2 reads addr 5 while `read_rdy` is low for 4 cycles, then high with `read_data`=1:
  - `read_en` is high exactly once, in the 5th ISSUE cycle.
  - `resp_rdata`=1 and err=0 at the next cycle.
- TIMEOUT=15, `write_rdy` held at 0:
  - `resp_valid[owner]` arrives with `resp_err`=1 after 16 cycles in ISSUE.
  - `write_en` never asserts.
  - The arbiter then returns to IDLE.
- Assert `RST_N`=0 between edges during ISSUE, with `rdy`=1:
  - `write_en`/`read_en`, `busy` and all outputs go to 0 immediately.
  - After release, the first grant goes to requester 0.
- Requester 1 drops `req_valid` before grant while requester 3 is pending:
  - Requester 3 is granted.
  - Requester 1 gets no `req_ready` and no response.
